// File: rtl/singlecycle_pkg.sv
// Shared types for the execute-to-writeback path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package singlecycle_pkg;

    localparam int WB_DEPTH  = 2;
    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;
    localparam int WB_PC_W   = 32;

    // Occupancy of the writeback buffer; doubles as the control FSM state.
    typedef enum logic [1:0] {
        WB_EMPTY,
        WB_ONE,
        WB_FULL
    } wb_state_e;

    typedef struct packed {
        logic [WB_DATA_W-1:0] alu_res;
        logic                 overflow;
        logic                 ovf_trap_en;
        logic                 rd_wren;
        logic [WB_ADDR_W-1:0] rd_addr;
        logic [WB_PC_W-1:0]   pc;
    } ex_wb_entry_t;

endpackage

// File: rtl/wb_skid_fifo.sv
// Two-entry storage FIFO of ex_wb_entry_t; occupancy is tracked by the owner.
// Latency: a push is visible at the head on the following cycle.
// Backpressure: none internally; the owner never pushes when full or pops when empty.
// Ports: i_clk/i_rst_n; i_push + i_push_dat write the tail; i_pop advances the head;
//        i_clear empties the FIFO (overrides push/pop); o_head_dat is the oldest entry.
module wb_skid_fifo
    import singlecycle_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_clear,
    input  ex_wb_entry_t i_push_dat,
    output ex_wb_entry_t o_head_dat
);

    localparam int PTR_W = $clog2(WB_DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    ex_wb_entry_t     mem_q [WB_DEPTH];
    ex_wb_entry_t     mem_d [WB_DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (i_push) begin
            mem_d[wr_ptr_q] = i_push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (i_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // Stale data left in mem is harmless: the owner reads the head only when non-empty.
        if (i_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < WB_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

    assign o_head_dat = mem_q[rd_ptr_q];

endmodule

// File: rtl/ex_wb_buffer.sv
// Execute-to-writeback buffer: retires ALU results in order to the register-file port,
// raises precise overflow traps, keeps a sticky overflow flag and a saturating count.
// Latency: pushed in cycle N, retires in N+1 at the earliest; o_ex_ready drops only when FULL.
// Ports: i_ex_valid/o_ex_ready + ALU fields in; i_wb_stall, i_flush, i_clr_sticky control;
//        o_rd_* register write, o_trap/o_trap_pc trap pulse, o_ovf_sticky/o_ovf_count status.
module ex_wb_buffer
    import singlecycle_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int PC_W   = WB_PC_W,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_ex_valid,
    output logic              o_ex_ready,
    input  logic [DATA_W-1:0] i_alu_res,
    input  logic              i_overflow,
    input  logic              i_ovf_trap_en,
    input  logic              i_rd_wren,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic [PC_W-1:0]   i_pc,
    input  logic              i_wb_stall,
    input  logic              i_flush,
    input  logic              i_clr_sticky,
    output logic              o_rd_wren,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_trap,
    output logic [PC_W-1:0]   o_trap_pc,
    output logic              o_ovf_sticky,
    output logic [CNT_W-1:0]  o_ovf_count
);

    wb_state_e        state_q, state_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

    ex_wb_entry_t push_dat;
    ex_wb_entry_t head_dat;
    logic         push_vld;
    logic         push_eff;
    logic         retire;
    logic         trap_cond;
    logic         clear;
    logic         ovf_retire;

    // Ready is a pure function of state; gating with reset keeps it low while reset is held.
    assign o_ex_ready = i_rst_n && (state_q != WB_FULL);
    assign push_vld   = i_ex_valid && o_ex_ready;

    always_comb begin
        push_dat             = '0;
        push_dat.alu_res     = i_alu_res;
        push_dat.overflow    = i_overflow;
        push_dat.ovf_trap_en = i_ovf_trap_en;
        push_dat.rd_wren     = i_rd_wren;
        push_dat.rd_addr     = i_rd_addr;
        push_dat.pc          = i_pc;
    end

    assign retire     = (state_q != WB_EMPTY) && !i_wb_stall;
    assign ovf_retire = retire && head_dat.overflow;
    assign trap_cond  = ovf_retire && head_dat.ovf_trap_en;
    // A trap squashes everything younger than the trapping instruction, same as a flush.
    assign clear      = i_flush || trap_cond;
    assign push_eff   = push_vld && !clear;

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = WB_EMPTY;
        end else begin
            case (state_q)
                WB_EMPTY: if (push_eff) state_d = WB_ONE;
                WB_ONE: begin
                    if (push_eff && !retire)      state_d = WB_FULL;
                    else if (!push_eff && retire) state_d = WB_EMPTY;
                end
                WB_FULL:  if (retire) state_d = WB_ONE;
                default:  state_d = WB_EMPTY;
            endcase
        end
    end

    always_comb begin
        sticky_d  = sticky_q;
        ovf_cnt_d = ovf_cnt_q;
        // Set has priority over clear so a same-cycle overflow is never lost.
        if (ovf_retire)        sticky_d = 1'b1;
        else if (i_clr_sticky) sticky_d = 1'b0;
        if (ovf_retire && (ovf_cnt_q != {CNT_W{1'b1}})) begin
            ovf_cnt_d = ovf_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= WB_EMPTY;
            sticky_q  <= 1'b0;
            ovf_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sticky_q  <= sticky_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    wb_skid_fifo u_fifo (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_push     (push_eff),
        .i_pop      (retire),
        .i_clear    (clear),
        .i_push_dat (push_dat),
        .o_head_dat (head_dat)
    );

    always_comb begin
        o_rd_wren = retire && head_dat.rd_wren && (head_dat.rd_addr != '0) && !trap_cond;
        o_rd_addr = o_rd_wren ? head_dat.rd_addr : '0;
        o_rd_data = o_rd_wren ? head_dat.alu_res : '0;
        o_trap    = trap_cond;
        o_trap_pc = trap_cond ? head_dat.pc : '0;
    end

    assign o_ovf_sticky = sticky_q;
    assign o_ovf_count  = ovf_cnt_q;

endmodule

// File: tb/tb_ex_wb_buffer.sv
// Bench for ex_wb_buffer: scoreboard of expected register writes plus an overflow model.
// Latency: n/a.
// Backpressure: exercised through i_wb_stall and a third push against a full buffer.
module tb_ex_wb_buffer;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_ex_valid;
    logic        o_ex_ready;
    logic [31:0] i_alu_res;
    logic        i_overflow;
    logic        i_ovf_trap_en;
    logic        i_rd_wren;
    logic [4:0]  i_rd_addr;
    logic [31:0] i_pc;
    logic        i_wb_stall;
    logic        i_flush;
    logic        i_clr_sticky;
    logic        o_rd_wren;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd_data;
    logic        o_trap;
    logic [31:0] o_trap_pc;
    logic        o_ovf_sticky;
    logic [3:0]  o_ovf_count;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        e;
    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_cnt = '0;
    logic       exp_sticky = 1'b0;

    // Narrow counter so saturation is reachable in a short run.
    ex_wb_buffer #(.CNT_W(4)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_ex_valid    (i_ex_valid),
        .o_ex_ready    (o_ex_ready),
        .i_alu_res     (i_alu_res),
        .i_overflow    (i_overflow),
        .i_ovf_trap_en (i_ovf_trap_en),
        .i_rd_wren     (i_rd_wren),
        .i_rd_addr     (i_rd_addr),
        .i_pc          (i_pc),
        .i_wb_stall    (i_wb_stall),
        .i_flush       (i_flush),
        .i_clr_sticky  (i_clr_sticky),
        .o_rd_wren     (o_rd_wren),
        .o_rd_addr     (o_rd_addr),
        .o_rd_data     (o_rd_data),
        .o_trap        (o_trap),
        .o_trap_pc     (o_trap_pc),
        .o_ovf_sticky  (o_ovf_sticky),
        .o_ovf_count   (o_ovf_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_ex_valid    = 1'b0;
        i_alu_res     = '0;
        i_overflow    = 1'b0;
        i_ovf_trap_en = 1'b0;
        i_rd_wren     = 1'b0;
        i_rd_addr     = '0;
        i_pc          = '0;
    endtask

    task automatic drive(input logic [31:0] res, input logic ovf, input logic ten,
                         input logic wen, input logic [4:0] rd, input logic [31:0] pc);
        i_ex_valid    = 1'b1;
        i_alu_res     = res;
        i_overflow    = ovf;
        i_ovf_trap_en = ten;
        i_rd_wren     = wen;
        i_rd_addr     = rd;
        i_pc          = pc;
    endtask

    function automatic void push_exp(input logic [4:0] rd, input logic [31:0] data);
        wr_t w;
        w.addr = rd;
        w.data = data;
        exp_q.push_back(w);
    endfunction

    function automatic void model_ovf();
        exp_sticky = 1'b1;
        if (exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
    endfunction

    task automatic test_reset();
        i_rst_n = 1'b0;
        idle();
        i_wb_stall = 1'b0; i_flush = 1'b0; i_clr_sticky = 1'b0;
        #2;
        checks++;
        if ({o_ex_ready, o_rd_wren, o_rd_addr, o_rd_data, o_trap, o_trap_pc, o_ovf_sticky, o_ovf_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b wren=%b trap=%b sticky=%b count=%h, all required 0",
                     o_ex_ready, o_rd_wren, o_trap, o_ovf_sticky, o_ovf_count);
        end
        tick(); tick();
        i_rst_n = 1'b1;
        @(negedge i_clk);
        checks++;
        if (o_ex_ready !== 1'b1 || o_rd_wren !== 1'b0 || o_ovf_sticky !== 1'b0 || o_ovf_count !== 4'h0) begin
            errors++;
            $display("FAIL reset_release: ready=%b wren=%b sticky=%b count=%h, required 1 0 0 0",
                     o_ex_ready, o_rd_wren, o_ovf_sticky, o_ovf_count);
        end
        tick();
    endtask

    task automatic test_single_add();
        drive(32'h0000_0010, 1'b0, 1'b0, 1'b1, 5'd5, 32'h40);
        push_exp(5'd5, 32'h10);
        tick();
        idle();
        @(negedge i_clk);
        checks++;
        if (o_rd_wren !== 1'b1) begin
            errors++;
            $display("FAIL single_wren: got %b required 1", o_rd_wren);
        end else begin
            e = exp_q.pop_front();
            if (o_rd_addr !== e.addr || o_rd_data !== e.data) begin
                errors++;
                $display("FAIL single_data: got %0d/%h required %0d/%h", o_rd_addr, o_rd_data, e.addr, e.data);
            end
        end
        tick();
        @(negedge i_clk);
        checks++;
        if (o_ex_ready !== 1'b1 || o_rd_wren !== 1'b0) begin
            errors++;
            $display("FAIL single_empty: ready=%b wren=%b required 1 0", o_ex_ready, o_rd_wren);
        end
        exp_q.delete();
        tick();
    endtask

    task automatic test_backpressure();
        i_wb_stall = 1'b1;
        drive(32'hA1, 1'b0, 1'b0, 1'b1, 5'd1, 32'h10); push_exp(5'd1, 32'hA1); tick();
        drive(32'hB2, 1'b0, 1'b0, 1'b1, 5'd2, 32'h14); push_exp(5'd2, 32'hB2); tick();
        drive(32'hC3, 1'b0, 1'b0, 1'b1, 5'd3, 32'h18);
        @(negedge i_clk);
        checks++;
        if (o_ex_ready !== 1'b0 || o_rd_wren !== 1'b0 || o_trap !== 1'b0) begin
            errors++;
            $display("FAIL bp_full_hold: ready=%b wren=%b trap=%b required 0 0 0", o_ex_ready, o_rd_wren, o_trap);
        end
        tick();
        idle();
        i_wb_stall = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge i_clk);
            checks++;
            if (o_rd_wren !== 1'b1) begin
                errors++;
                $display("FAIL bp_order_wren[%0d]: got %b required 1", i, o_rd_wren);
            end else begin
                e = exp_q.pop_front();
                if (o_rd_addr !== e.addr || o_rd_data !== e.data) begin
                    errors++;
                    $display("FAIL bp_order[%0d]: got %0d/%h required %0d/%h", i, o_rd_addr, o_rd_data, e.addr, e.data);
                end
            end
            tick();
        end
        @(negedge i_clk);
        checks++;
        if (o_rd_wren !== 1'b0) begin
            errors++;
            $display("FAIL bp_third_dropped: wren=%b addr=%0d required no write", o_rd_wren, o_rd_addr);
        end
        exp_q.delete();
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            drive(32'h100 + i, 1'b0, 1'b0, 1'b1, 5'(10 + i), 32'h200 + 4 * i);
            push_exp(5'(10 + i), 32'h100 + i);
            @(negedge i_clk);
            checks++;
            if (o_ex_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: got %b required 1", i, o_ex_ready);
            end
            if (i > 0) begin
                checks++;
                e = exp_q.pop_front();
                if (o_rd_wren !== 1'b1 || o_rd_addr !== e.addr || o_rd_data !== e.data) begin
                    errors++;
                    $display("FAIL b2b_write[%0d]: got %b/%0d/%h required 1/%0d/%h",
                             i, o_rd_wren, o_rd_addr, o_rd_data, e.addr, e.data);
                end
            end
            tick();
        end
        idle();
        for (int c = 0; c < 8 && exp_q.size() > 0; c++) begin
            @(negedge i_clk);
            if (o_rd_wren === 1'b1) begin
                e = exp_q.pop_front();
                checks++;
                if (o_rd_addr !== e.addr || o_rd_data !== e.data) begin
                    errors++;
                    $display("FAIL b2b_tail: got %0d/%h required %0d/%h", o_rd_addr, o_rd_data, e.addr, e.data);
                end
            end
            tick();
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_timeout: %0d writes outstanding, required 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_x0_write();
        drive(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 5'd0, 32'h80);
        tick();
        idle();
        @(negedge i_clk);
        checks++;
        if (o_rd_wren !== 1'b0 || o_rd_addr !== 5'd0 || o_rd_data !== 32'h0 || o_ovf_count !== exp_cnt) begin
            errors++;
            $display("FAIL x0_write: wren=%b addr=%0d data=%h count=%h required 0/0/0/%h",
                     o_rd_wren, o_rd_addr, o_rd_data, o_ovf_count, exp_cnt);
        end
        tick();
    endtask

    task automatic test_trap();
        i_wb_stall = 1'b1;
        drive(32'h8000_0000, 1'b1, 1'b1, 1'b1, 5'd7, 32'h100); tick();
        drive(32'h55, 1'b0, 1'b0, 1'b1, 5'd8, 32'h104); tick();
        idle();
        i_wb_stall = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_trap !== 1'b1 || o_trap_pc !== 32'h100 || o_rd_wren !== 1'b0) begin
            errors++;
            $display("FAIL trap_pulse: trap=%b pc=%h wren=%b required 1/00000100/0", o_trap, o_trap_pc, o_rd_wren);
        end
        model_ovf();
        tick();
        @(negedge i_clk);
        checks++;
        if (o_trap !== 1'b0 || o_rd_wren !== 1'b0 || o_ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL trap_younger_dropped: trap=%b wren=%b ready=%b required 0 0 1", o_trap, o_rd_wren, o_ex_ready);
        end
        checks++;
        if (o_ovf_sticky !== exp_sticky || o_ovf_count !== exp_cnt) begin
            errors++;
            $display("FAIL trap_status: sticky=%b count=%h required %b/%h", o_ovf_sticky, o_ovf_count, exp_sticky, exp_cnt);
        end
        // Trapping head with a push offered in the same cycle.
        drive(32'h8000_0001, 1'b1, 1'b1, 1'b1, 5'd9, 32'h200); tick();
        drive(32'h66, 1'b0, 1'b0, 1'b1, 5'd10, 32'h204);
        @(negedge i_clk);
        checks++;
        if (o_trap !== 1'b1 || o_trap_pc !== 32'h200) begin
            errors++;
            $display("FAIL trap_push_pulse: trap=%b pc=%h required 1/00000200", o_trap, o_trap_pc);
        end
        model_ovf();
        tick();
        idle();
        @(negedge i_clk);
        checks++;
        if (o_rd_wren !== 1'b0 || o_trap !== 1'b0 || o_ovf_count !== exp_cnt) begin
            errors++;
            $display("FAIL trap_push_dropped: wren=%b trap=%b count=%h required 0/0/%h", o_rd_wren, o_trap, o_ovf_count, exp_cnt);
        end
        tick();
    endtask

    task automatic test_ovf_notrap();
        drive(32'h8000_0000, 1'b1, 1'b0, 1'b1, 5'd3, 32'h300);
        push_exp(5'd3, 32'h8000_0000);
        tick();
        idle();
        @(negedge i_clk);
        checks++;
        e = exp_q.pop_front();
        if (o_rd_wren !== 1'b1 || o_rd_addr !== e.addr || o_rd_data !== e.data || o_trap !== 1'b0) begin
            errors++;
            $display("FAIL notrap_write: got %b/%0d/%h trap=%b required 1/%0d/%h trap=0",
                     o_rd_wren, o_rd_addr, o_rd_data, o_trap, e.addr, e.data);
        end
        model_ovf();
        tick();
        @(negedge i_clk);
        checks++;
        if (o_ovf_count !== exp_cnt || o_ovf_sticky !== exp_sticky) begin
            errors++;
            $display("FAIL notrap_count: count=%h sticky=%b required %h/%b", o_ovf_count, o_ovf_sticky, exp_cnt, exp_sticky);
        end
        i_clr_sticky = 1'b1;
        tick();
        i_clr_sticky = 1'b0;
        exp_sticky = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_ovf_sticky !== exp_sticky) begin
            errors++;
            $display("FAIL sticky_clear: got %b required %b", o_ovf_sticky, exp_sticky);
        end
        drive(32'h8000_0002, 1'b1, 1'b0, 1'b0, 5'd4, 32'h304);
        tick();
        idle();
        i_clr_sticky = 1'b1;
        tick();
        i_clr_sticky = 1'b0;
        model_ovf();
        @(negedge i_clk);
        checks++;
        if (o_ovf_sticky !== exp_sticky || o_ovf_count !== exp_cnt) begin
            errors++;
            $display("FAIL set_beats_clear: sticky=%b count=%h required %b/%h", o_ovf_sticky, o_ovf_count, exp_sticky, exp_cnt);
        end
        for (int i = 0; i < 16; i++) begin
            drive(32'h8000_0000 + i, 1'b1, 1'b0, 1'b0, 5'd6, 32'h400 + 4 * i);
            tick();
            model_ovf();
        end
        idle();
        tick(); tick();
        @(negedge i_clk);
        checks++;
        if (o_ovf_count !== exp_cnt || o_ovf_count !== 4'hF) begin
            errors++;
            $display("FAIL count_saturate: got %h required %h", o_ovf_count, exp_cnt);
        end
        tick();
    endtask

    task automatic test_flush_reset();
        drive(32'h99, 1'b0, 1'b0, 1'b1, 5'd9, 32'h500);
        push_exp(5'd9, 32'h99);
        tick();
        drive(32'h77, 1'b0, 1'b0, 1'b1, 5'd11, 32'h504);
        i_flush = 1'b1;
        @(negedge i_clk);
        checks++;
        e = exp_q.pop_front();
        if (o_rd_wren !== 1'b1 || o_rd_addr !== e.addr || o_rd_data !== e.data) begin
            errors++;
            $display("FAIL flush_head_retires: got %b/%0d/%h required 1/%0d/%h",
                     o_rd_wren, o_rd_addr, o_rd_data, e.addr, e.data);
        end
        tick();
        idle();
        i_flush = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_rd_wren !== 1'b0 || o_ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_push_dropped: wren=%b ready=%b required 0 1", o_rd_wren, o_ex_ready);
        end
        tick();
        i_wb_stall = 1'b1;
        drive(32'h11, 1'b1, 1'b0, 1'b1, 5'd12, 32'h600); tick();
        drive(32'h22, 1'b0, 1'b0, 1'b1, 5'd13, 32'h604); tick();
        idle();
        i_flush = 1'b1;
        @(negedge i_clk);
        checks++;
        if (o_ex_ready !== 1'b0 || o_rd_wren !== 1'b0) begin
            errors++;
            $display("FAIL flush_full_stalled: ready=%b wren=%b required 0 0", o_ex_ready, o_rd_wren);
        end
        tick();
        i_flush = 1'b0;
        i_wb_stall = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_ex_ready !== 1'b1 || o_rd_wren !== 1'b0 || o_ovf_sticky !== exp_sticky || o_ovf_count !== exp_cnt) begin
            errors++;
            $display("FAIL flush_empty: ready=%b wren=%b sticky=%b count=%h required 1/0/%b/%h",
                     o_ex_ready, o_rd_wren, o_ovf_sticky, o_ovf_count, exp_sticky, exp_cnt);
        end
        tick();
        i_wb_stall = 1'b1;
        drive(32'h33, 1'b0, 1'b0, 1'b1, 5'd14, 32'h700); tick();
        drive(32'h44, 1'b0, 1'b0, 1'b1, 5'd15, 32'h704); tick();
        idle();
        @(negedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        checks++;
        if ({o_ex_ready, o_rd_wren, o_rd_addr, o_rd_data, o_trap, o_trap_pc, o_ovf_sticky, o_ovf_count} !== '0) begin
            errors++;
            $display("FAIL async_reset: ready=%b wren=%b trap=%b sticky=%b count=%h, all required 0",
                     o_ex_ready, o_rd_wren, o_trap, o_ovf_sticky, o_ovf_count);
        end
        exp_cnt = '0;
        exp_sticky = 1'b0;
        tick();
        i_rst_n = 1'b1;
        i_wb_stall = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_ex_ready !== 1'b1 || o_rd_wren !== 1'b0 || o_ovf_count !== exp_cnt) begin
            errors++;
            $display("FAIL reset_recover: ready=%b wren=%b count=%h required 1/0/%h", o_ex_ready, o_rd_wren, o_ovf_count, exp_cnt);
        end
        exp_q.delete();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_backpressure();
        test_back_to_back();
        test_x0_write();
        test_trap();
        test_ovf_notrap();
        test_flush_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
